chunked_add_seq: RTL and testbench
==================================

Name: chunked_add_seq

Overview:
Multi-cycle sequencer that computes a wide add (OP_W = SLICE_W*NSLICE bits) on a single narrow SLICE_W-bit ripple-carry slice. It holds the slice carry in a register, walks the slices from least to most significant, and presents the full sum and carry-out with a done pulse. It sits between a requester (start/operand handshake) and the shared ripple adder datapath, and trades latency for adder area.

Parameters:
SLICE_W, 2, width of the ripple adder slice in bits (>=1)
NSLICE, 4, number of slices per operation (>=1); OP_W = SLICE_W*NSLICE

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted only when ready=1
a  input  OP_W  operand A, sampled on accept
b  input  OP_W  operand B, sampled on accept
ci  input  1  carry-in, sampled on accept
ready  output  1  1 in IDLE and DONE, 0 in RUN
busy  output  1  1 in RUN
done  output  1  1-cycle pulse, result valid
sum  output  OP_W  result, held until the next accept
co  output  1  final carry-out, held with sum

Behaviour:
- Interface: one clock (clk); asynchronous active-high reset (reset).
- Reset, asynchronous: state=IDLE, slice index=0, carry reg=0, sum=0, co=0, done=0, busy=0, ready=1. Reset asserted mid-RUN aborts the operation with no done pulse.
- FSM states are IDLE, RUN and DONE.
- IDLE, start=1: latch a, b and ci (carry reg<=ci, idx<=0), then go to RUN.
- RUN, each cycle, for slice k=idx:
  - sum[k*SLICE_W +: SLICE_W] <= a_k ^ b_k ^ ripple carries.
  - carry reg <= carry-out of the slice.
  - idx <= idx+1.
- RUN leaves after the slice with idx=NSLICE-1: co <= slice carry-out, go to DONE.
- DONE lasts one cycle with done=1. start=1 in DONE is accepted (same rules as IDLE, go to RUN). Otherwise go to IDLE.
- Latency: accept at edge T gives done=1 during cycle T+NSLICE+1. Sustained throughput is one operation per NSLICE+1 cycles.
- start while busy=1 is ignored and is not queued. a, b and ci changing during RUN have no effect, because the operands are latched.
- Within a slice, carries ripple bit by bit: c[i+1] = a&b | a&c | b&c. Slice carry-in is the carry reg.
- sum bits of slices not yet computed keep their previous values until overwritten. Consumers use sum/co only at or after done.
- Arithmetic is unsigned modulo 2^OP_W. co is bit OP_W of a+b+ci.
- Index counter width is clog2(NSLICE), minimum 1 bit. With NSLICE=1, RUN lasts exactly one cycle.

Optional Feature:
Macro CHUNK_ADD_SUB_EN.
- Defined: adds input port sub (1 bit), sampled on accept. sub=1 makes the block latch ~b and force the carry reg to 1, ignoring ci. The result is a-b in two's complement, with co=1 meaning no borrow. sub=0 behaves exactly as the undefined build.
- Undefined: no sub port. The block is add-only, and its timing is identical in both builds.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a clog2 helper function.
- Natural sub-module: ripple_add_slice, which is combinational. Parameter is SLICE_W. Ports are a, b, ci in and s, co out, built from per-bit majority/xor cells.
- The sequencer instantiates one ripple_add_slice and owns the operand/sum registers, carry reg, index counter and FSM.

Test Plan:
- Basic add, default params: start with a=8'h5A, b=8'h3C, ci=0 -> done 5 cycles after accept; sum=8'h96, co=0; busy=1 for exactly 4 cycles.
- Full carry propagation: a=8'hFF, b=8'h01, ci=0 -> sum=8'h00, co=1. Also a=8'hFF, b=8'hFF, ci=1 -> sum=8'hFF, co=1.
- Start while busy: accept a=8'h01, b=8'h01; pulse start with a=8'h80 two cycles later -> only one done, sum=8'h02. Back-to-back start held through DONE -> second op accepted in the DONE cycle, done again 5 cycles later.
- Reset mid-operation: assert reset during the 2nd RUN cycle -> sum=0, co=0, busy=0, ready=1 immediately; no done pulse. A fresh add after release is correct.
- Exhaustive compare, SLICE_W=2, NSLICE=1: all 32 {ci,b,a} combinations -> {co,sum} == a+b+ci with done at accept+2. Repeat with SLICE_W=1, NSLICE=2 for the identical 32 sums.
- CHUNK_ADD_SUB_EN defined:
  - a=8'h10, b=8'h01, sub=1 -> sum=8'h0F, co=1.
  - a=8'h00, b=8'h01, sub=1 -> sum=8'hFF, co=0.

Source files
------------

// File: rtl/chunked_add_seq_pkg.sv
// rtl/chunked_add_seq_pkg.sv - shared FSM encoding and width helper for chunked_add_seq
package chunked_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index counter width; never less than one bit so NSLICE=1 still has a counter
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/chunked_add_seq_ripple_add_slice.sv
// rtl/chunked_add_seq_ripple_add_slice.sv - combinational SLICE_W-bit ripple-carry adder slice
module ripple_add_slice #(
    parameter int SLICE_W = 2
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign s[i]     = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end

    assign co = w_c[SLICE_W];

endmodule

// File: rtl/chunked_add_seq.sv
// rtl/chunked_add_seq.sv - wide add sequenced over one narrow ripple slice
// Optional subtract port enabled by defining CHUNK_ADD_SUB_EN.
module chunked_add_seq
    import chunked_add_seq_pkg::*;
#(
    parameter int SLICE_W = 2,
    parameter int NSLICE  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [SLICE_W*NSLICE-1:0]  a,
    input  logic [SLICE_W*NSLICE-1:0]  b,
    input  logic                       ci,
`ifdef CHUNK_ADD_SUB_EN
    input  logic                       sub,
`endif
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*NSLICE-1:0]  sum,
    output logic                       co
);

    localparam int OP_W  = SLICE_W * NSLICE;
    localparam int IDX_W = clog2_min1(NSLICE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [OP_W-1:0]    r_a;
    logic [OP_W-1:0]    r_b;
    logic [OP_W-1:0]    r_sum;
    logic               r_carry;
    logic               r_co;
    logic [IDX_W-1:0]   r_idx;

    logic               w_accept;
    logic               w_last;
    logic [OP_W-1:0]    w_b_in;
    logic               w_ci_in;
    logic [SLICE_W-1:0] w_sa;
    logic [SLICE_W-1:0] w_sb;
    logic [SLICE_W-1:0] w_ss;
    logic               w_sco;

`ifdef CHUNK_ADD_SUB_EN
    // Subtract as a + ~b + 1; the forced carry-in replaces ci
    assign w_b_in  = sub ? ~b : b;
    assign w_ci_in = sub | ci;
`else
    assign w_b_in  = b;
    assign w_ci_in = ci;
`endif

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last   = (r_idx == LAST_IDX);

    assign w_sa = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_sb = r_b[r_idx*SLICE_W +: SLICE_W];

    ripple_add_slice #(
        .SLICE_W(SLICE_W)
    ) u_slice (
        .a  (w_sa),
        .b  (w_sb),
        .ci (r_carry),
        .s  (w_ss),
        .co (w_sco)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= w_b_in;
            r_carry <= w_ci_in;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            // Upper sum slices keep stale bits until their turn comes
            r_sum[r_idx*SLICE_W +: SLICE_W] <= w_ss;
            r_carry <= w_sco;
            if (w_last) begin
                r_co  <= w_sco;
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign ready = (r_state != ST_RUN);
    assign busy  = (r_state == ST_RUN);
    assign done  = (r_state == ST_DONE);
    assign sum   = r_sum;
    assign co    = r_co;

endmodule

// File: tb/tb_chunked_add_seq.sv
// tb/tb_chunked_add_seq.sv - scoreboard bench for chunked_add_seq (default and two small configs)
module tb_chunked_add_seq;

    typedef struct {
        logic [8:0] val;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    logic       start0 = 1'b0;
    logic [7:0] a0 = '0, b0 = '0;
    logic       ci0 = 1'b0;
    logic       sub0 = 1'b0;
    logic       ready0, busy0, done0, co0;
    logic [7:0] sum0;

    logic       start_n = 1'b0;
    logic [1:0] an = '0, bn = '0;
    logic       cin = 1'b0;
    logic       ready1, busy1, done1, co1;
    logic [1:0] sum1;
    logic       ready2, busy2, done2, co2;
    logic [1:0] sum2;

    exp_t q0[$], q1[$], q2[$];
    exp_t e0, e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_add_seq #(.SLICE_W(2), .NSLICE(4)) dut0 (
        .clk(clk), .reset(rst), .start(start0), .a(a0), .b(b0), .ci(ci0),
`ifdef CHUNK_ADD_SUB_EN
        .sub(sub0),
`endif
        .ready(ready0), .busy(busy0), .done(done0), .sum(sum0), .co(co0)
    );

    chunked_add_seq #(.SLICE_W(2), .NSLICE(1)) dut1 (
        .clk(clk), .reset(rst), .start(start_n), .a(an), .b(bn), .ci(cin),
`ifdef CHUNK_ADD_SUB_EN
        .sub(1'b0),
`endif
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .co(co1)
    );

    chunked_add_seq #(.SLICE_W(1), .NSLICE(2)) dut2 (
        .clk(clk), .reset(rst), .start(start_n), .a(an), .b(bn), .ci(cin),
`ifdef CHUNK_ADD_SUB_EN
        .sub(1'b0),
`endif
        .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .co(co2)
    );

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s done pulse with no pending request", nm);
    endtask

    always @(negedge clk) begin
        if (!rst && done0) begin
            if (q0.size() == 0) unexpected("d0_done");
            else begin
                e0 = q0.pop_front();
                check("d0_result", {co0, sum0}, e0.val);
                check("d0_latency", cyc, e0.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done1) begin
            if (q1.size() == 0) unexpected("d1_done");
            else begin
                e1 = q1.pop_front();
                check("d1_result", {co1, sum1}, e1.val);
                check("d1_latency", cyc, e1.due);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done2) begin
            if (q2.size() == 0) unexpected("d2_done");
            else begin
                e2 = q2.pop_front();
                check("d2_result", {co2, sum2}, e2.val);
                check("d2_latency", cyc, e2.due);
            end
        end
    end

    // Called at a falling edge; the accept happens on the following rising edge
    task automatic issue0(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic sub, input logic [8:0] expv, input bit push);
        a0 = a; b0 = b; ci0 = ci; sub0 = sub; start0 = 1'b1;
        if (push) q0.push_back('{val: expv, due: cyc + 5});
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((q0.size() + q1.size() + q2.size()) != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", q0.size() + q1.size() + q2.size());
            q0.delete(); q1.delete(); q2.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        logic [8:0] s;
        #3;
        check("rst_sum", sum0, 0);
        check("rst_co", co0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ready", ready0, 1);
        check("rst_done", done0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue0(8'h5A, 8'h3C, 1'b0, 1'b0, 9'h096, 1'b1);
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            nb += int'(busy0);
            @(negedge clk);
        end
        check("busy_cycles", nb, 4);
        drain();

        issue0(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b1);
        drain();
        issue0(8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b1);
        drain();

        issue0(8'h01, 8'h01, 1'b0, 1'b0, 9'h002, 1'b1);
        @(negedge clk);
        a0 = 8'h80; start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        drain();
        repeat (6) @(negedge clk);

        a0 = 8'h12; b0 = 8'h34; ci0 = 1'b0; start0 = 1'b1;
        q0.push_back('{val: 9'h046, due: cyc + 5});
        @(negedge clk);
        a0 = 8'hF0; b0 = 8'h20; ci0 = 1'b1;
        q0.push_back('{val: 9'h111, due: cyc + 9});
        repeat (5) @(negedge clk);
        start0 = 1'b0;
        drain();

        issue0(8'h33, 8'h11, 1'b0, 1'b0, 9'h000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_sum", sum0, 0);
        check("midrst_co", co0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_ready", ready0, 1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        issue0(8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1);
        drain();

`ifdef CHUNK_ADD_SUB_EN
        issue0(8'h10, 8'h01, 1'b0, 1'b1, 9'h10F, 1'b1);
        drain();
        issue0(8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF, 1'b1);
        drain();
`endif

        for (int i = 0; i < 32; i++) begin
            an = i[1:0]; bn = i[3:2]; cin = i[4];
            s = 9'(an) + 9'(bn) + 9'(cin);
            start_n = 1'b1;
            q1.push_back('{val: s, due: cyc + 2});
            q2.push_back('{val: s, due: cyc + 3});
            @(negedge clk);
            start_n = 1'b0;
            repeat (3) @(negedge clk);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
